// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-addressed data memory: byte-address decode,
// sub-word load extension, read-modify-write for SB/SH, and request error flagging.
module dmem_lsu #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clkin,
   input  logic        nrst_in,
   input  logic        req_valid_in,
   output logic        req_ready_out,
   input  logic        req_we_in,
   input  logic [2:0]  req_funct3_in,
   input  logic [31:0] req_addr_in,
   input  logic [31:0] req_wdata_in,
   output logic        resp_valid_out,
   output logic [31:0] resp_rdata_out,
   output logic        resp_err_out,
   output logic [31:0] mem_rd_addr_out,
   input  logic [31:0] mem_rd_data_in,
   output logic        mem_wr_en_out,
   output logic [31:0] mem_wr_addr_out,
   output logic [31:0] mem_wr_data_out
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MERGE, S_WRITE, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        req_illegal, req_misal, req_oor, req_err;
   logic [31:0] word_idx;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;
   logic [31:0] merged;

   // Errors are decided from the incoming fields so the accept edge can branch straight to RESP.
   always_comb begin
      if (req_we_in)
         req_illegal = req_funct3_in[2] | (req_funct3_in[1:0] == 2'b11);
      else
         req_illegal = (req_funct3_in == 3'b011) | (req_funct3_in[2:1] == 2'b11);
      req_misal = ((req_funct3_in[1:0] == 2'b01) & req_addr_in[0]) |
                  ((req_funct3_in[1:0] == 2'b10) & (req_addr_in[1:0] != 2'b00));
      req_oor   = {2'b00, req_addr_in[31:2]} >= 32'(MEM_WORDS);
      req_err   = req_illegal | req_misal | req_oor;
   end

   assign word_idx = {2'b00, addr_q[31:2]};
   assign ld_byte  = mem_rd_data_in[8*addr_q[1:0] +: 8];
   assign ld_half  = addr_q[1] ? mem_rd_data_in[31:16] : mem_rd_data_in[15:0];

   always_comb begin
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = mem_rd_data_in;
      endcase
   end

   always_comb begin
      merged = mem_rd_data_in;
      if (funct3_q[0])
         merged[16*addr_q[1] +: 16] = wdata_q;
      else
         merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
   end

   always_ff @(posedge clkin) begin
      if (!nrst_in) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Every output is gated by nrst_in so nothing leaks while reset is held.
   always_comb begin
      state_d         = state_q;
      req_ready_out   = 1'b0;
      resp_valid_out  = 1'b0;
      resp_err_out    = 1'b0;
      mem_rd_addr_out = 32'd0;
      mem_wr_en_out   = 1'b0;
      mem_wr_addr_out = 32'd0;
      mem_wr_data_out = 32'd0;
      if (nrst_in) begin
         case (state_q)
            S_IDLE: begin
               req_ready_out = 1'b1;
               if (req_valid_in) begin
                  if (req_err)                          state_d = S_RESP;
                  else if (!req_we_in)                  state_d = S_LOAD;
                  else if (req_funct3_in[1:0] == 2'b10) state_d = S_WRITE;
                  else                                  state_d = S_MERGE;
               end
            end
            S_LOAD: begin
               mem_rd_addr_out = word_idx;
               state_d         = S_RESP;
            end
            S_MERGE: begin
               mem_rd_addr_out = word_idx;
               state_d         = S_WRITE;
            end
            S_WRITE: begin
               mem_wr_en_out   = 1'b1;
               mem_wr_addr_out = word_idx;
               mem_wr_data_out = word_q;
               state_d         = S_RESP;
            end
            S_RESP: begin
               resp_valid_out = 1'b1;
               resp_err_out   = err_q;
               state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign resp_rdata_out = nrst_in ? rdata_q : 32'd0;

   always_ff @(posedge clkin) begin
      if (!nrst_in) begin
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 16'd0;
         word_q   <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid_in) begin
               funct3_q <= req_funct3_in;
               addr_q   <= req_addr_in;
               wdata_q  <= req_wdata_in[15:0];
               word_q   <= req_wdata_in;
               err_q    <= req_err;
               if (req_err) rdata_q <= 32'd0;
            end
            S_LOAD:  rdata_q <= ld_ext;
            S_MERGE: word_q  <= merged;
            S_WRITE: rdata_q <= 32'd0;
            default: ;
         endcase
      end
   end

endmodule
